// File: rtl/pulse_pacer_pkg.sv
// Shared types and defaults for the pulse pacer: FSM state encoding,
// default counter width and inter-pulse gap, and the gap-timer width helper.
package pulse_pacer_pkg;

    localparam int CW_DEFAULT  = 8;
    localparam int GAP_DEFAULT = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bits needed to hold a countdown that starts at gap-1 and ends at 0.
    function automatic int timer_width(input int gap);
        return $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/pulse_pacer_gap_timer.sv
// Gap countdown for the pulse pacer: loads GAP-1 on load, counts down to 0
// and holds there; done is high whenever the count has reached 0.
module pulse_pacer_gap_timer
    import pulse_pacer_pkg::*;
#(
    parameter int GAP = GAP_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    output logic done
);

    localparam int            TW       = timer_width(GAP);
    localparam logic [TW-1:0] LOAD_VAL = TW'(GAP - 1);
    localparam logic [TW-1:0] ONE      = TW'(1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next count: reload, decrement, or rest at zero.
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = LOAD_VAL;
        end else if (timer_q != '0) begin
            timer_d = timer_q - ONE;
        end else begin
            timer_d = timer_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign done = (timer_q == '0);

endmodule

// File: rtl/pulse_pacer.sv
// Event pacer: queues input events in a saturating counter and re-emits them
// as single-cycle pulses at least GAP cycles apart. Define
// PULSE_PACER_OVERFLOW_EN to build the sticky overflow flag.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int CW  = CW_DEFAULT,
    parameter int GAP = GAP_DEFAULT
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in,
    output logic          out,
    output logic [CW-1:0] pending,
    output logic          busy,
    output logic          overflow
);

    localparam logic [CW-1:0] PEND_MAX = '1;
    localparam logic [CW-1:0] PEND_ONE = CW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] pending_q;
    logic [CW-1:0] pending_d;
    logic          out_q;
    logic          out_d;
    logic          busy_q;
    logic          busy_d;
    logic          avail_s;
    logic          dec_s;
    logic          drop_s;
    logic          gap_done_s;
    logic          timer_load_s;

    assign timer_load_s = (state_q == ST_PULSE);

    pulse_pacer_gap_timer #(
        .GAP (GAP)
    ) u_gap_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load_s),
        .done    (gap_done_s)
    );

    // Next state and queue bookkeeping; a decrement happens exactly on PULSE entry.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        avail_s   = (pending_q != '0) || in;
        case (state_q)
            ST_IDLE: begin
                if (avail_s) begin
                    state_d = ST_PULSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_done_s && avail_s) begin
                    state_d = ST_PULSE;
                end else if (gap_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dec_s  = (state_d == ST_PULSE);
        drop_s = in && !dec_s && (pending_q == PEND_MAX);

        // Without in, a decrement only occurs when pending is nonzero.
        if (dec_s && !in) begin
            pending_d = pending_q - PEND_ONE;
        end else if (!dec_s && in && !drop_s) begin
            pending_d = pending_q + PEND_ONE;
        end else begin
            pending_d = pending_q;
        end

        out_d  = dec_s;
        busy_d = (state_d != ST_IDLE) || (pending_d != '0);
    end

    // State, queue depth and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
        end
    end

    assign out     = out_q;
    assign pending = pending_q;
    assign busy    = busy_q;

`ifdef PULSE_PACER_OVERFLOW_EN
    logic overflow_q;
    logic overflow_d;

    // Sticky drop flag, cleared only by reset.
    always_comb begin
        overflow_d = overflow_q || drop_s;
    end

    // Drop flag register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer: four instances (default, CW=2, GAP=1, GAP=255).
module tb_pulse_pacer;

    logic       clock;
    logic       reset_n;
    logic       in_main, in_sat, in_g1, in_g255;
    logic       out_main, out_sat, out_g1, out_g255;
    logic [7:0] pend_main, pend_g1, pend_g255;
    logic [1:0] pend_sat;
    logic       busy_main, busy_sat, busy_g1, busy_g255;
    logic       ovf_main, ovf_sat, ovf_g1, ovf_g255;

    int vectors;
    int miscompares;

`ifdef PULSE_PACER_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    pulse_pacer #(.CW(8), .GAP(7)) u_main (
        .clock(clock), .reset_n(reset_n), .in(in_main), .out(out_main),
        .pending(pend_main), .busy(busy_main), .overflow(ovf_main));
    pulse_pacer #(.CW(2), .GAP(7)) u_sat (
        .clock(clock), .reset_n(reset_n), .in(in_sat), .out(out_sat),
        .pending(pend_sat), .busy(busy_sat), .overflow(ovf_sat));
    pulse_pacer #(.CW(8), .GAP(1)) u_g1 (
        .clock(clock), .reset_n(reset_n), .in(in_g1), .out(out_g1),
        .pending(pend_g1), .busy(busy_g1), .overflow(ovf_g1));
    pulse_pacer #(.CW(8), .GAP(255)) u_g255 (
        .clock(clock), .reset_n(reset_n), .in(in_g255), .out(out_g255),
        .pending(pend_g255), .busy(busy_g255), .overflow(ovf_g255));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset_n = 1'b0;
        in_main = 1'b0; in_sat = 1'b0; in_g1 = 1'b0; in_g255 = 1'b0;
        repeat (3) @(negedge clock);
        vectors += 5;
        if (out_main !== 1'b0) begin miscompares++; $display("FAIL reset_out: got %b want 0", out_main); end
        if (pend_main !== 8'd0) begin miscompares++; $display("FAIL reset_pending: got %0d want 0", pend_main); end
        if (busy_main !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_main); end
        if (ovf_main !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf_main); end
        if (busy_g255 !== 1'b0) begin miscompares++; $display("FAIL reset_busy_g255: got %b want 0", busy_g255); end
        // First edge after release must sample in.
        in_main = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        in_main = 1'b0;
        vectors += 2;
        if (out_main !== 1'b1) begin miscompares++; $display("FAIL first_edge_out: got %b want 1", out_main); end
        if (pend_main !== 8'd0) begin miscompares++; $display("FAIL first_edge_pending: got %0d want 0", pend_main); end
        repeat (10) @(negedge clock);
        vectors++;
        if (busy_main !== 1'b0) begin miscompares++; $display("FAIL first_edge_idle: busy got %b want 0", busy_main); end
    endtask

    task automatic test_single();
        in_main = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            in_main = 1'b0;
            vectors += 3;
            if (out_main !== (k == 0)) begin miscompares++; $display("FAIL single_out k=%0d: got %b want %b", k, out_main, (k == 0)); end
            if (busy_main !== (k <= 7)) begin miscompares++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy_main, (k <= 7)); end
            if (pend_main !== 8'd0) begin miscompares++; $display("FAIL single_pending k=%0d: got %0d want 0", k, pend_main); end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_p;
        in_main = 1'b1;
        for (int k = 0; k < 35; k++) begin
            @(negedge clock);
            if (k == 3) in_main = 1'b0;
            exp_p = (k < 3) ? 8'(k) : (k < 8) ? 8'd3 : (k < 16) ? 8'd2 : (k < 24) ? 8'd1 : 8'd0;
            vectors += 3;
            if (out_main !== ((k % 8 == 0) && (k <= 24))) begin miscompares++; $display("FAIL burst_out k=%0d: got %b", k, out_main); end
            if (pend_main !== exp_p) begin miscompares++; $display("FAIL burst_pending k=%0d: got %0d want %0d", k, pend_main, exp_p); end
            if (busy_main !== (k <= 31)) begin miscompares++; $display("FAIL burst_busy k=%0d: got %b want %b", k, busy_main, (k <= 31)); end
        end
    endtask

    task automatic test_simultaneous();
        in_main = 1'b1;
        for (int k = 0; k < 35; k++) begin
            @(negedge clock);
            in_main = (k < 2) || (k == 7);
            if (k == 7 || k == 8) begin
                vectors++;
                if (pend_main !== 8'd2) begin miscompares++; $display("FAIL simul_pending k=%0d: got %0d want 2", k, pend_main); end
            end
            if (k == 8 || k == 16 || k == 24) begin
                vectors++;
                if (out_main !== 1'b1) begin miscompares++; $display("FAIL simul_out k=%0d: got %b want 1", k, out_main); end
            end
            if (k == 16) begin
                vectors++;
                if (pend_main !== 8'd1) begin miscompares++; $display("FAIL simul_drain: got %0d want 1", pend_main); end
            end
        end
        vectors += 2;
        if (pend_main !== 8'd0) begin miscompares++; $display("FAIL simul_final_pending: got %0d want 0", pend_main); end
        if (busy_main !== 1'b0) begin miscompares++; $display("FAIL simul_final_busy: got %b want 0", busy_main); end
    endtask

    task automatic test_reset_mid();
        in_main = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (k == 5) in_main = 1'b0;
        end
        vectors++;
        if (pend_main !== 8'd5) begin miscompares++; $display("FAIL mid_setup_pending: got %0d want 5", pend_main); end
        reset_n = 1'b0;
        #1;
        vectors += 4;
        if (out_main !== 1'b0) begin miscompares++; $display("FAIL mid_out: got %b want 0", out_main); end
        if (pend_main !== 8'd0) begin miscompares++; $display("FAIL mid_pending: got %0d want 0", pend_main); end
        if (busy_main !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy_main); end
        if (ovf_main !== 1'b0) begin miscompares++; $display("FAIL mid_ovf: got %b want 0", ovf_main); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            vectors += 2;
            if (out_main !== 1'b0) begin miscompares++; $display("FAIL mid_quiet_out k=%0d: got %b want 0", k, out_main); end
            if (pend_main !== 8'd0) begin miscompares++; $display("FAIL mid_quiet_pending k=%0d: got %0d want 0", k, pend_main); end
        end
        // Cut a pulse in flight.
        in_main = 1'b1;
        @(negedge clock);
        in_main = 1'b0;
        vectors++;
        if (out_main !== 1'b1) begin miscompares++; $display("FAIL cut_setup_out: got %b want 1", out_main); end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_main !== 1'b0) begin miscompares++; $display("FAIL cut_out: got %b want 0", out_main); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            vectors++;
            if (out_main !== 1'b0) begin miscompares++; $display("FAIL cut_quiet_out k=%0d: got %b want 0", k, out_main); end
        end
    endtask

    task automatic test_saturation();
        int pulses;
        logic [1:0] exp_p;
        pulses = 0;
        in_sat = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 5) in_sat = 1'b0;
            if (out_sat === 1'b1) pulses++;
            if (k < 6) begin
                exp_p = (k < 3) ? 2'(k) : 2'd3;
                vectors++;
                if (pend_sat !== exp_p) begin miscompares++; $display("FAIL sat_pending k=%0d: got %0d want %0d", k, pend_sat, exp_p); end
            end
        end
        vectors += 3;
        if (pulses !== 4) begin miscompares++; $display("FAIL sat_pulses: got %0d want 4", pulses); end
        if (pend_sat !== 2'd0) begin miscompares++; $display("FAIL sat_final_pending: got %0d want 0", pend_sat); end
        if (ovf_sat !== OVF_EXP) begin miscompares++; $display("FAIL sat_ovf: got %b want %b", ovf_sat, OVF_EXP); end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ovf_sat !== 1'b0) begin miscompares++; $display("FAIL sat_ovf_clear: got %b want 0", ovf_sat); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_spacing(input bit sel, input int gap, input int cycles, input int odds);
        int accepted, emitted, last;
        logic o;
        accepted = 0; emitted = 0; last = -1;
        for (int k = 0; k <= cycles; k++) begin
            @(negedge clock);
            o = sel ? out_g255 : out_g1;
            if (o === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (k - last < gap + 1) begin miscompares++; $display("FAIL spacing_gap%0d: pulses %0d apart, need %0d", gap, k - last, gap + 1); end
                end
                last = k;
                emitted++;
            end
            if (k < cycles) begin
                if (sel) in_g255 = ($urandom_range(odds - 1, 0) == 0);
                else     in_g1   = ($urandom_range(odds - 1, 0) == 0);
                if ((sel ? in_g255 : in_g1) === 1'b1) accepted++;
            end else begin
                in_g1 = 1'b0; in_g255 = 1'b0;
            end
        end
        vectors++;
        if (emitted + int'(sel ? pend_g255 : pend_g1) !== accepted) begin
            miscompares++;
            $display("FAIL spacing_conserve_gap%0d: emitted+pending %0d, accepted %0d", gap,
                     emitted + int'(sel ? pend_g255 : pend_g1), accepted);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_burst();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        test_spacing(1'b0, 1, 400, 4);
        test_spacing(1'b1, 255, 700, 16);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_pacer.md
PULSE_PACER -- requirements
Module: pulse_pacer

Interface
REQ-001 Parameter CW, default 8: width of the pending-event counter; saturates at 2^CW-1.
REQ-002 Parameter GAP, default 7: minimum low cycles between output pulses; legal range 1..255; default matches an NB=3 receiver-side stretch.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in  input  1  event input; each cycle sampled high counts as one event.
REQ-006 out  output  1  paced event pulse, exactly one cycle high per event, registered.
REQ-007 pending  output  CW  events accepted but not yet emitted, registered.
REQ-008 busy  output  1  high when state is not IDLE or pending is nonzero, registered.
REQ-009 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-010 The module SHALL forward every accepted event as one single-cycle out pulse, in order, with at least GAP low cycles between consecutive pulses.
REQ-011 The module SHALL use the states IDLE, PULSE and GAP; PULSE lasts exactly one cycle; GAP lasts exactly GAP cycles.
REQ-012 Let avail = (pending != 0) | in. In IDLE, avail SHALL cause PULSE next cycle; otherwise remain IDLE.
REQ-013 PULSE SHALL always go to GAP; out SHALL be 1 only while in PULSE.
REQ-014 On the last GAP cycle, avail SHALL cause PULSE next; otherwise IDLE. No idle cycle is inserted between back-to-back pacing periods (period = GAP+1).
REQ-015 Latency: with IDLE and pending=0, in high at edge t SHALL give out high in cycle t+1 and SHALL leave pending at 0.
REQ-016 On the transition into PULSE, pending SHALL update to pending + in - 1; on other cycles, pending SHALL update to pending + in.
REQ-017 When in and a decrement occur in the same cycle, pending SHALL be unchanged.
REQ-018 When pending = 2^CW-1, in is high and no decrement occurs, the event SHALL be dropped, pending SHALL hold, and the overflow condition SHALL be raised; pending SHALL never wrap.
REQ-019 The GAP timer SHALL be ceil(log2(GAP+1)) bits wide, load GAP-1 on entering GAP, and count down to 0.

Reset
REQ-020 While reset_n is low: state=IDLE, out=0, pending=0, busy=0, overflow=0, timer=0.
REQ-021 Reset asserted mid-operation SHALL discard all pending events; an in-flight pulse SHALL be cut immediately.
REQ-022 The first edge after reset_n deassertion SHALL sample in normally.

Configuration
REQ-023 With macro PULSE_PACER_OVERFLOW_EN defined, overflow SHALL set on any dropped event and clear only on reset.
REQ-024 Without PULSE_PACER_OVERFLOW_EN, overflow SHALL be constant 0 and no overflow register shall exist; drop behaviour per REQ-018 is unchanged.

Structure
REQ-025 Package pulse_pacer_pkg SHALL hold the state enum (IDLE, PULSE, GAP) and the default constants for CW and GAP.
REQ-026 The GAP countdown SHALL be a sub-module pulse_pacer_gap_timer with inputs load/clock/reset_n and output done.

Verification
REQ-027 Single event: in high for 1 cycle from IDLE -> out high next cycle only; busy high for GAP+1 cycles; pending stays 0.
REQ-028 Burst: in high for 4 consecutive cycles, GAP=7 -> 4 out pulses at cycles t+1, t+9, t+17, t+25; pending peaks at 3 and returns to 0.
REQ-029 Saturation: CW=2, in high for 6 cycles -> pending saturates at 3; 4 pulses emitted in total; overflow=1 with the macro, 0 without.
REQ-030 Simultaneous event: in high exactly on a PULSE-entry cycle while pending=2 -> pending remains 2.
REQ-031 Reset mid-burst: reset_n low during GAP with pending=5 -> out, pending, busy and overflow go to 0 at once; no pulses after release without new in.
REQ-032 Spacing check against GAP=1 and GAP=255 under random in -> no two out pulses closer than GAP+1 cycles; emitted count + final pending = accepted count.
